// File: rtl/wb_ram_arbiter_pkg.sv
// Shared Wishbone cycle-type constants and the grant-FSM state encoding used by
// the two-master RAM arbiter and its bench.
package wb_ram_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC   = 3'b000;
  localparam logic [2:0] CTI_INC_BURST = 3'b010;
  localparam logic [2:0] CTI_END_BURST = 3'b111;
  localparam logic [1:0] BTE_LINEAR    = 2'b00;

  // State bits double as the one-hot grant vector: bit 0 = m0, bit 1 = m1.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_GNT0 = 2'b01,
    ARB_GNT1 = 2'b10
  } arb_state_t;

endpackage

// File: rtl/wb_ram_arbiter_if.sv
// One Wishbone B3 bus segment; master modport for the initiator side, slave
// modport for the target side.
interface wb_ram_arbiter_if #(
  parameter int dw = 32,
  parameter int aw = 32
);
  logic [aw-1:0]   adr;
  logic [dw-1:0]   dat_w;
  logic [dw-1:0]   dat_r;
  logic [dw/8-1:0] sel;
  logic            we;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cti, bte, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cti, bte, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arb_rr2.sv
// Two-requester round-robin grant FSM; a grant is held for as long as the
// owner keeps its request (cyc) high.
module wb_arb_rr2
  import wb_ram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  arb_state_t state, state_nxt;
  logic       last_gnt;  // 0 = m0, 1 = m1

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state && state_nxt != ARB_IDLE)
        last_gnt <= (state_nxt == ARB_GNT1);
    end
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (req == 2'b11)     state_nxt = last_gnt ? ARB_GNT0 : ARB_GNT1;
        else if (req[0])      state_nxt = ARB_GNT0;
        else if (req[1])      state_nxt = ARB_GNT1;
      end
      ARB_GNT0: begin
        if (!req[0])          state_nxt = req[1] ? ARB_GNT1 : ARB_IDLE;
      end
      ARB_GNT1: begin
        if (!req[1])          state_nxt = req[0] ? ARB_GNT0 : ARB_IDLE;
      end
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt = {state == ARB_GNT1, state == ARB_GNT0};

endmodule

// File: rtl/wb_ram_arbiter.sv
// Shares one Wishbone RAM slave between the instruction (m0) and data (m1)
// masters; the grant FSM is registered, all bus muxing is combinational.
module wb_ram_arbiter
  import wb_ram_arbiter_pkg::*;
#(
  parameter int dw = 32,
  parameter int aw = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_ram_arbiter_if.slave   m0,
  wb_ram_arbiter_if.slave   m1,
  wb_ram_arbiter_if.master  s
);

  logic [1:0]      gnt;
  logic [aw-1:0]   adr_mux;
  logic [dw-1:0]   dat_mux;
  logic [dw/8-1:0] sel_mux;
  logic            we_mux;
  logic [2:0]      cti_mux;
  logic [1:0]      bte_mux;

  wb_arb_rr2 u_arb (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .req ({m1.cyc, m0.cyc}),
    .gnt (gnt)
  );

  // Idle and GNT0 both pass m0, so only the m1 grant switches the mux.
  always_comb begin
    adr_mux = m0.adr;
    dat_mux = m0.dat_w;
    sel_mux = m0.sel;
    we_mux  = m0.we;
    cti_mux = m0.cti;
    bte_mux = m0.bte;
    if (gnt[1]) begin
      adr_mux = m1.adr;
      dat_mux = m1.dat_w;
      sel_mux = m1.sel;
      we_mux  = m1.we;
      cti_mux = m1.cti;
      bte_mux = m1.bte;
    end
  end

  assign s.adr   = adr_mux;
  assign s.dat_w = dat_mux;
  assign s.sel   = sel_mux;
  assign s.we    = we_mux;
  assign s.cti   = cti_mux;
  assign s.bte   = bte_mux;
  assign s.cyc   = (gnt[0] & m0.cyc) | (gnt[1] & m1.cyc);
  assign s.stb   = (gnt[0] & m0.cyc & m0.stb) | (gnt[1] & m1.cyc & m1.stb);

  // Read data is broadcast; handshake responses reach only the owner.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = gnt[0] & s.ack;
  assign m1.ack   = gnt[1] & s.ack;
  assign m0.err   = gnt[0] & s.err;
  assign m1.err   = gnt[1] & s.err;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed/randomised bench for wb_ram_arbiter: a zero-wait RAM slave, an
// expected-RAM image and an expected grant-order model.
module tb_wb_ram_arbiter;
  import wb_ram_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_ram_arbiter_if #(.dw(32), .aw(32)) m0_bus ();
  wb_ram_arbiter_if #(.dw(32), .aw(32)) m1_bus ();
  wb_ram_arbiter_if #(.dw(32), .aw(32)) s_bus ();

  wb_ram_arbiter #(.dw(32), .aw(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0       (m0_bus),
    .m1       (m1_bus),
    .s        (s_bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem      [256];
  logic [31:0] init_img [256];
  logic [31:0] ref_mem  [256];
  logic        load_mem   = 1'b0;
  logic        err_inject = 1'b0;
  int          cycle = 0;
  bit          model_last;  // expected most recently granted master

  typedef struct {
    int          m;
    logic [2:0]  cti;
    logic [31:0] adr;
    int          cyc;
  } beat_t;
  beat_t log_q[$];

  // Zero-wait RAM slave: responds in the same cycle as stb.
  always_comb begin
    s_bus.ack   = s_bus.cyc & s_bus.stb & ~err_inject;
    s_bus.err   = s_bus.cyc & s_bus.stb & err_inject;
    s_bus.dat_r = mem[s_bus.adr[9:2]];
  end

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_img[i];
    end else if (s_bus.cyc && s_bus.stb && s_bus.ack && s_bus.we) begin
      mem[s_bus.adr[9:2]] <= s_bus.dat_w;
    end
    if (s_bus.cyc && s_bus.stb && s_bus.ack)
      log_q.push_back('{m: m1_bus.ack ? 1 : (m0_bus.ack ? 0 : -1),
                        cti: s_bus.cti, adr: s_bus.adr, cyc: cycle});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int m, input logic cyc, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
    if (m == 0) begin
      m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we; m0_bus.adr = adr;
      m0_bus.dat_w = dat; m0_bus.cti = cti; m0_bus.bte = BTE_LINEAR; m0_bus.sel = '1;
    end else begin
      m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we; m1_bus.adr = adr;
      m1_bus.dat_w = dat; m1_bus.cti = cti; m1_bus.bte = BTE_LINEAR; m1_bus.sel = '1;
    end
  endtask

  function automatic logic get_ack(input int m);
    return (m == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction

  function automatic logic [31:0] get_dat(input int m);
    return (m == 0) ? m0_bus.dat_r : m1_bus.dat_r;
  endfunction

  // One Wishbone cycle of 'beats' beats; called and returns at posedge+1,
  // leaving one idle cycle with cyc low after the last beat.
  task automatic master_cycle(input int m, input bit we, input logic [31:0] base,
                              input int beats, output logic [31:0] rdata);
    logic [31:0] wd;
    logic [31:0] a;
    logic [2:0]  cti;
    int          waits;
    bit          timed_out;
    timed_out = 1'b0;
    rdata = '0;
    for (int b = 0; b < beats; b++) begin
      a   = base + 32'(4 * b);
      wd  = $urandom;
      cti = (beats == 1) ? CTI_CLASSIC : ((b == beats - 1) ? CTI_END_BURST : CTI_INC_BURST);
      set_m(m, 1'b1, we, a, wd, cti);
      waits = 0;
      do begin
        @(negedge clk);
        waits++;
      end while (!get_ack(m) && waits < 60);
      if (!get_ack(m)) begin
        timed_out = 1'b1;
        break;
      end
      rdata = get_dat(m);
      if (we) ref_mem[a[9:2]] = wd;
      @(posedge clk); #1;
    end
    set_m(m, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    check($sformatf("ack_timeout_m%0d", m), 64'(timed_out), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_ram(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [31:0] rd0, rd1, a0, a1, d0;
    int          e0, exp_m;
    logic [2:0]  exp_cti;

    for (int i = 0; i < 256; i++) begin
      init_img[i] = $urandom;
      ref_mem[i]  = init_img[i];
    end
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    set_m(1, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    load_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1 load_mem = 1'b0;

    // Reset state, even with a request pending.
    set_m(0, 1'b1, 1'b0, 32'h10, '0, CTI_CLASSIC);
    @(negedge clk);
    check("rst_s_cyc",  64'(s_bus.cyc),  64'd0);
    check("rst_s_stb",  64'(s_bus.stb),  64'd0);
    check("rst_m0_ack", 64'(m0_bus.ack), 64'd0);
    check("rst_m1_ack", 64'(m1_bus.ack), 64'd0);
    check("rst_errs",   64'({m0_bus.err, m1_bus.err}), 64'd0);
    check("rst_gnt",    64'(dut.u_arb.gnt), 64'd0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    rst = 1'b0;
    model_last = 1'b1;

    // Idle passthrough of m0 address/data.
    a0 = {22'd0, 8'($urandom), 2'b00};
    a1 = ~a0;
    d0 = $urandom;
    m0_bus.adr = a0; m0_bus.dat_w = d0; m1_bus.adr = a1;
    @(negedge clk);
    check("idle_s_adr",  64'(s_bus.adr),   64'(a0));
    check("idle_s_dat",  64'(s_bus.dat_w), 64'(d0));
    check("idle_s_cyc",  64'(s_bus.cyc),   64'd0);
    @(posedge clk); #1;

    // 1: asynchronous reset in the middle of an m0 burst.
    set_m(0, 1'b1, 1'b0, 32'h20, '0, CTI_INC_BURST);
    @(negedge clk);
    check("burst_pre_cyc", 64'(s_bus.cyc), 64'd0);
    @(negedge clk);
    check("burst_s_cyc",  64'(s_bus.cyc),  64'd1);
    check("burst_m0_ack", 64'(m0_bus.ack), 64'd1);
    @(posedge clk); #1;
    m0_bus.adr = 32'h24;
    #2 rst = 1'b1;
    #1;
    check("midrst_s_cyc",  64'(s_bus.cyc),  64'd0);
    check("midrst_m0_ack", 64'(m0_bus.ack), 64'd0);
    check("midrst_gnt",    64'(dut.u_arb.gnt), 64'd0);
    set_m(0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;

    // 2: single requester, classic read of 0x10.
    set_m(0, 1'b1, 1'b0, 32'h10, '0, CTI_CLASSIC);
    @(negedge clk);
    check("single_cyc_lat", 64'(s_bus.cyc), 64'd0);
    @(negedge clk);
    check("single_s_cyc",  64'(s_bus.cyc),   64'd1);
    check("single_s_stb",  64'(s_bus.stb),   64'd1);
    check("single_s_adr",  64'(s_bus.adr),   64'h10);
    check("single_m0_ack", 64'(m0_bus.ack),  64'd1);
    check("single_m0_dat", 64'(m0_bus.dat_r), 64'(ref_mem[4]));
    check("single_m1_ack", 64'(m1_bus.ack),  64'd0);
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    model_last = 1'b0;
    @(negedge clk);
    check("single_drop_cyc", 64'(s_bus.cyc), 64'd0);
    @(posedge clk); #1;

    // 3: simultaneous requests straight after reset.
    rst = 1'b1;
    #2 rst = 1'b0;
    model_last = 1'b1;
    @(posedge clk); #1;
    log_q.delete();
    fork
      master_cycle(0, 1'b1, 32'h40, 1, rd0);
      master_cycle(1, 1'b1, 32'h44, 1, rd1);
    join
    e0 = model_last ? 0 : 1;
    check("tie_beats", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("tie_first",  64'(log_q[0].m), 64'(e0));
      check("tie_second", 64'(log_q[1].m), 64'(1 - e0));
      check("tie_dead_cycle", 64'(log_q[1].cyc - log_q[0].cyc), 64'd2);
      model_last = (e0 == 0);
    end

    // 4: m1 4-beat incrementing burst is not broken by an m0 request.
    log_q.delete();
    fork
      master_cycle(1, 1'b1, 32'h20, 4, rd1);
      begin
        @(posedge clk); #1;
        master_cycle(0, 1'b0, 32'h30, 1, rd0);
      end
    join
    check("lock_beats", 64'(log_q.size()), 64'd5);
    if (log_q.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        exp_cti = (i == 3) ? CTI_END_BURST : CTI_INC_BURST;
        check($sformatf("lock_owner_%0d", i), 64'(log_q[i].m),   64'd1);
        check($sformatf("lock_adr_%0d", i),   64'(log_q[i].adr), 64'(32'h20 + 32'(4 * i)));
        check($sformatf("lock_cti_%0d", i),   64'(log_q[i].cti), 64'(exp_cti));
      end
      check("lock_m0_after", 64'(log_q[4].m), 64'd0);
    end
    check("lock_m0_rdata", 64'(rd0), 64'(ref_mem[12]));
    model_last = 1'b0;
    check_ram("lock_ram");

    // 5: fairness with both masters re-requesting single writes.
    log_q.delete();
    fork
      for (int i = 0; i < 10; i++)
        master_cycle(0, 1'b1, 32'h200 + 32'(4 * $urandom_range(0, 63)), 1, rd0);
      for (int i = 0; i < 10; i++)
        master_cycle(1, 1'b1, 32'h300 + 32'(4 * $urandom_range(0, 63)), 1, rd1);
    join
    check("fair_grants", 64'(log_q.size()), 64'd20);
    e0 = model_last ? 0 : 1;
    for (int i = 0; i < log_q.size() && i < 20; i++) begin
      exp_m = (i % 2 == 0) ? e0 : 1 - e0;
      check($sformatf("fair_owner_%0d", i), 64'(log_q[i].m), 64'(exp_m));
    end
    model_last = (e0 == 0);  // 20 alternating grants end on the other master
    @(posedge clk); #1;
    check_ram("fair_ram");

    // 6: slave error during an m1 beat; grant is kept.
    err_inject = 1'b1;
    set_m(1, 1'b1, 1'b0, 32'h300, '0, CTI_CLASSIC);
    @(negedge clk);
    @(negedge clk);
    check("err_m1_err", 64'(m1_bus.err), 64'd1);
    check("err_m0_err", 64'(m0_bus.err), 64'd0);
    check("err_m1_ack", 64'(m1_bus.ack), 64'd0);
    @(posedge clk); #1;
    set_m(0, 1'b1, 1'b0, 32'h200, '0, CTI_CLASSIC);
    @(negedge clk);
    check("err_hold_m1_err", 64'(m1_bus.err), 64'd1);
    check("err_hold_m0_err", 64'(m0_bus.err), 64'd0);
    check("err_hold_m0_ack", 64'(m0_bus.ack), 64'd0);
    @(posedge clk); #1;
    err_inject = 1'b0;
    @(negedge clk);
    check("err_clear_m1_ack", 64'(m1_bus.ack), 64'd1);
    check("err_clear_m0_ack", 64'(m0_bus.ack), 64'd0);
    @(posedge clk); #1;
    set_m(1, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    @(negedge clk);
    check("handover_dead", 64'(m0_bus.ack), 64'd0);
    @(negedge clk);
    check("handover_m0_ack", 64'(m0_bus.ack), 64'd1);
    check("handover_m0_dat", 64'(m0_bus.dat_r), 64'(ref_mem[32'h200 >> 2]));
    @(posedge clk); #1;
    set_m(0, 1'b0, 1'b0, '0, '0, CTI_CLASSIC);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
